// File: rtl/matricula_display.sv
// Six-digit multiplexed 7-segment scanner with a frame-synchronous shadow register.
// Define MATRICULA_LZB_EN to compile in leading-zero blanking.
module matricula_display #(
    parameter int PRESCALE = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       EN,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [3:0] C,
    input  logic [3:0] D,
    input  logic [3:0] E,
    input  logic [3:0] F,
    output logic [5:0] AN,
    output logic [6:0] SEG,
    output logic       DP,
    output logic       FRAME
);

    localparam int PCW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PCW-1:0] PC_MAX = PCW'(PRESCALE - 1);

    logic [PCW-1:0] pc_q, pc_d;
    logic [2:0]     idx_q, idx_d;
    logic [23:0]    sh_q, sh_d;
    logic [5:0]     an_q, an_d;
    logic [6:0]     seg_q, seg_d;
    logic           frame_q, frame_d;

    logic [23:0] digits;
    logic        tick;
    logic        lastSlot;
    logic [3:0]  curNib;

    assign digits   = {A, B, C, D, E, F};
    assign tick     = EN && (pc_q == PC_MAX);
    assign lastSlot = (idx_q == 3'd5);

    function automatic logic [6:0] hexToSeg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        case (idx_q)
            3'd0:    curNib = sh_q[23:20];
            3'd1:    curNib = sh_q[19:16];
            3'd2:    curNib = sh_q[15:12];
            3'd3:    curNib = sh_q[11:8];
            3'd4:    curNib = sh_q[7:4];
            default: curNib = sh_q[3:0];
        endcase
    end

`ifdef MATRICULA_LZB_EN
    logic blankCur;
    logic leadZero;

    // Digit F is never a candidate, so an all-zero shadow still shows a single 0.
    always_comb begin
        blankCur = 1'b0;
        leadZero = 1'b1;
        for (int k = 0; k < 5; k++) begin
            leadZero = leadZero && (sh_q[(23 - 4*k) -: 4] == 4'h0);
            if ((idx_q == 3'(k)) && leadZero) begin
                blankCur = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        pc_d    = pc_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        an_d    = an_q;
        seg_d   = seg_q;
        frame_d = 1'b0;
        if (!EN) begin
            pc_d  = '0;
            idx_d = 3'd0;
            sh_d  = digits;
            an_d  = 6'h3F;
            seg_d = 7'h7F;
        end else begin
            pc_d = tick ? '0 : pc_q + 1'b1;
            if (tick) begin
                idx_d = lastSlot ? 3'd0 : idx_q + 3'd1;
            end
            // New digits are latched only at the frame boundary so a frame never tears.
            if (tick && lastSlot) begin
                sh_d    = digits;
                frame_d = 1'b1;
            end
            an_d = ~(6'd1 << (3'd5 - idx_q));
`ifdef MATRICULA_LZB_EN
            seg_d = blankCur ? 7'h7F : hexToSeg(curNib);
`else
            seg_d = hexToSeg(curNib);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            idx_q   <= 3'd0;
            sh_q    <= 24'h0;
            an_q    <= 6'h3F;
            seg_q   <= 7'h7F;
            frame_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            frame_q <= frame_d;
        end
    end

    assign AN    = an_q;
    assign SEG   = seg_q;
    assign DP    = 1'b1;
    assign FRAME = frame_q;

endmodule

// File: tb/tb_matricula_display.sv
// Self-checking bench for matricula_display (PRESCALE=4) against a slot/frame arithmetic model.
// Honours MATRICULA_LZB_EN in the reference model when it is defined for the build.
module tb_matricula_display;

    localparam int P         = 4;
    localparam int FRAME_LEN = 6 * P;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    localparam logic [5:0] AN_SEQ [6]  = '{6'h1F, 6'h2F, 6'h37, 6'h3B, 6'h3D, 6'h3E};
    localparam logic [6:0] SEG_123 [6] = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
    localparam logic [6:0] SEG_ABC [6] = '{7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [23:0] digitsIn;
    logic [5:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame;

    int checks = 0;
    int errors = 0;

    logic [23:0] mShadow;
    int          mEnCycles;
    logic [5:0]  expAn;
    logic [6:0]  expSeg;
    logic        expFrame;

    matricula_display #(.PRESCALE(P)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .EN    (en),
        .A     (digitsIn[23:20]),
        .B     (digitsIn[19:16]),
        .C     (digitsIn[15:12]),
        .D     (digitsIn[11:8]),
        .E     (digitsIn[7:4]),
        .F     (digitsIn[3:0]),
        .AN    (an),
        .SEG   (seg),
        .DP    (dp),
        .FRAME (frame)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Segment pattern the model expects for slot k of shadow value v.
    function automatic logic [6:0] digitSeg(input logic [23:0] v, input int k);
        logic [3:0] d;
        d = v[(23 - 4*k) -: 4];
`ifdef MATRICULA_LZB_EN
        if (k < 5 && (v >> (4 * (5 - k))) == 24'h0) return 7'h7F;
`endif
        return SEG_TAB[d];
    endfunction

    function automatic logic [23:0] randomDigits();
        logic [23:0] r;
        r = 24'($urandom);
        case ($urandom_range(0, 4))
            0:       return r & 24'h000FFF;
            1:       return r & 24'h0000FF;
            2:       return 24'h0;
            3:       return r & 24'h0F0F0F;
            default: return r;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mShadow   = 24'h0;
        mEnCycles = 0;
        expAn     = 6'h3F;
        expSeg    = 7'h7F;
        expFrame  = 1'b0;
    endtask

    task automatic modelEdge();
        int slot;
        if (!rst_n) begin
            modelReset();
            return;
        end
        if (!en) begin
            expAn     = 6'h3F;
            expSeg    = 7'h7F;
            expFrame  = 1'b0;
            mShadow   = digitsIn;
            mEnCycles = 0;
        end else begin
            slot          = (mEnCycles / P) % 6;
            expAn         = 6'h3F;
            expAn[5-slot] = 1'b0;
            expSeg        = digitSeg(mShadow, slot);
            expFrame      = (mEnCycles % FRAME_LEN) == FRAME_LEN - 1;
            if (expFrame) mShadow = digitsIn;
            mEnCycles++;
        end
    endtask

    task automatic applyStimulus(input logic e, input logic [23:0] d);
        en       = e;
        digitsIn = d;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkOutput("an",    32'(an),    32'(expAn));
        checkOutput("seg",   32'(seg),   32'(expSeg));
        checkOutput("frame", 32'(frame), 32'(expFrame));
        checkOutput("dp",    32'(dp),    32'd1);
    endtask

    initial begin
        int lastPulse;
        int pulses;
        rst_n    = 1'b1;
        en       = 1'b0;
        digitsIn = 24'h0;
        modelReset();
        #1 rst_n = 1'b0;
        #2;
        checkOutput("rstAn",    32'(an),    32'h3F);
        checkOutput("rstSeg",   32'(seg),   32'h7F);
        checkOutput("rstDp",    32'(dp),    32'd1);
        checkOutput("rstFrame", 32'(frame), 32'd0);
        stepCycle();
        stepCycle();
        rst_n = 1'b1;

        // Basic scan of 123456 with the spec's directed sequence.
        applyStimulus(1'b0, 24'h123456);
        stepCycle();
        applyStimulus(1'b1, 24'h123456);
        for (int i = 0; i < FRAME_LEN; i++) begin
            stepCycle();
            checkOutput("an027",    32'(an),    32'(AN_SEQ[i / P]));
            checkOutput("seg027",   32'(seg),   32'(SEG_123[i / P]));
            checkOutput("frame027", 32'(frame), 32'(i == FRAME_LEN - 1));
        end

        // Change inputs during slot 2; the change appears only in the following frame.
        for (int i = 0; i < 2 * P + 1; i++) stepCycle();
        applyStimulus(1'b1, 24'hABCDEF);
        for (int i = 2 * P + 1; i < FRAME_LEN; i++) begin
            stepCycle();
            checkOutput("seg028old", 32'(seg), 32'(SEG_123[i / P]));
        end
        for (int i = 0; i < FRAME_LEN; i++) begin
            stepCycle();
            checkOutput("seg028new", 32'(seg), 32'(SEG_ABC[i / P]));
        end

        // Drop EN during slot 3, then re-raise and expect a full first slot on A.
        for (int i = 0; i < 3 * P + 1; i++) stepCycle();
        applyStimulus(1'b0, 24'hABCDEF);
        stepCycle();
        checkOutput("an029off",  32'(an),  32'h3F);
        checkOutput("seg029off", 32'(seg), 32'h7F);
        stepCycle();
        stepCycle();
        applyStimulus(1'b1, 24'hABCDEF);
        for (int i = 0; i < P; i++) begin
            stepCycle();
            checkOutput("an029slotA", 32'(an), 32'h1F);
        end
        stepCycle();
        checkOutput("an029slotB", 32'(an), 32'h2F);

        // Randomised digits and EN activity.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) digitsIn = randomDigits();
            if (en && $urandom_range(0, 39) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 2) == 0) en = 1'b1;
            stepCycle();
        end

        // Asynchronous reset in the middle of slot 4.
        applyStimulus(1'b0, 24'h654321);
        stepCycle();
        applyStimulus(1'b1, 24'h654321);
        for (int i = 0; i < 4 * P + 1; i++) stepCycle();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("an030async",    32'(an),    32'h3F);
        checkOutput("seg030async",   32'(seg),   32'h7F);
        checkOutput("frame030async", 32'(frame), 32'd0);
        modelReset();
        stepCycle();
        stepCycle();
        rst_n = 1'b1;
        for (int i = 0; i < FRAME_LEN; i++) begin
            stepCycle();
`ifdef MATRICULA_LZB_EN
            checkOutput("seg030zero", 32'(seg), (i / P == 5) ? 32'h40 : 32'h7F);
`else
            checkOutput("seg030zero", 32'(seg), 32'h40);
`endif
        end
        for (int i = 0; i < FRAME_LEN; i++) stepCycle();

        // Leading-zero patterns.
        applyStimulus(1'b0, 24'h000305);
        stepCycle();
        applyStimulus(1'b1, 24'h000305);
        for (int i = 0; i < FRAME_LEN; i++) stepCycle();
        applyStimulus(1'b0, 24'h000000);
        stepCycle();
        applyStimulus(1'b1, 24'h000000);
        for (int i = 0; i < FRAME_LEN; i++) stepCycle();

        // FRAME pulse width and spacing over ten frames.
        applyStimulus(1'b0, 24'h2468AC);
        stepCycle();
        applyStimulus(1'b1, 24'h2468AC);
        lastPulse = -1;
        pulses    = 0;
        for (int i = 0; i < 10 * FRAME_LEN; i++) begin
            stepCycle();
            if (frame === 1'b1) begin
                pulses++;
                if (lastPulse >= 0) checkOutput("frameGap", 32'(i - lastPulse), 32'(FRAME_LEN));
                lastPulse = i;
            end
        end
        checkOutput("frameCount", 32'(pulses), 32'd10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matricula_display.md
MATRICULA_DISPLAY -- requirements
Module: matricula_display

Interface
REQ-001 Parameter PRESCALE, default 50000: clock cycles each digit slot is displayed; legal range 2..2^20.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 EN  input  1  display enable; low blanks the display and holds the scan at its start.
REQ-005 A, B, C, D, E, F  input  4 each  digit nibbles; A is the most significant (leftmost) digit, F the least significant.
REQ-006 AN  output  6  anode selects, active-low; AN[5] is the leftmost digit (A), AN[0] the rightmost (F).
REQ-007 SEG  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-008 DP  output  1  decimal point, active-low; held high (off) in all cases.
REQ-009 FRAME  output  1  one-cycle pulse marking the end of a six-digit frame.

Function
REQ-010 Prescaler PC counts 0..PRESCALE-1 while EN=1, then wraps to 0; the wrap cycle is the slot tick.
REQ-011 Scan index IDX counts 0..5; it advances on each slot tick and wraps from 5 to 0.
REQ-012 Shadow register SH (24 bits) captures {A,B,C,D,E,F} every cycle while EN=0, and at the slot tick where IDX=5 while EN=1; digits therefore change only at frame boundaries, with no tearing.
REQ-013 IDX=k selects shadow nibble k, where k=0 is A and k=5 is F.
REQ-014 AN and SEG are registered with one-cycle latency from IDX/SH; when EN=1, AN has exactly one bit low, bit 5-IDX.
REQ-015 Hex decode to SEG (active-low): 0=40h, 1=79h, 2=24h, 3=30h, 4=19h, 5=12h, 6=02h, 7=78h, 8=00h, 9=10h, A=08h, b=03h, C=46h, d=21h, E=06h, F=0Eh.
REQ-016 FRAME is registered; it goes high for exactly one cycle, in the cycle after the slot tick with IDX=5.
REQ-017 EN=0 forces the following synchronously: PC=0, IDX=0, AN=3Fh, SEG=7Fh, FRAME=0.
REQ-018 EN rising: the first slot displays A with the SH value captured in the final EN=0 cycle; AN=1Fh appears one cycle after the first EN=1 cycle.
REQ-019 Input changes mid-frame have no effect on SEG until after the next FRAME pulse.
REQ-020 Each full frame lasts exactly 6*PRESCALE cycles; each AN pattern holds exactly PRESCALE cycles.

Reset
REQ-021 rst_n low asynchronously sets PC=0, IDX=0, SH=0, AN=3Fh, SEG=7Fh, DP=1, FRAME=0.
REQ-022 Reset deassertion is sampled synchronously; the first count occurs at the first rising edge with rst_n=1 and EN=1.
REQ-023 Reset asserted mid-frame abandons the frame; no FRAME pulse is emitted.

Configuration
REQ-024 Macro MATRICULA_LZB_EN compiles in leading-zero blanking.
REQ-025 With MATRICULA_LZB_EN: any shadow digit equal to 0 that is left of the first non-zero digit outputs SEG=7Fh during its slot, while its anode is still driven; digit F is never blanked, so all-zero input shows "0" on F only.
REQ-026 Without MATRICULA_LZB_EN: all six digits are always decoded per REQ-015, and no blanking logic is present.

Verification (PRESCALE=4)
REQ-027 Reset, then EN=1 with inputs 123456h -> AN sequence 1Fh,2Fh,37h,3Bh,3Dh,3Eh, 4 cycles each; SEG sequence 79h,24h,30h,19h,12h,02h; FRAME pulses every 24 cycles.
REQ-028 Inputs changed from 123456h to ABCDEFh during slot 2 -> rest of frame still shows 3,4,5,6; next frame shows 08h,03h,46h,21h,06h,0Eh.
REQ-029 EN dropped during slot 3 -> next cycle AN=3Fh, SEG=7Fh; on EN re-raise, scan restarts at A with a full 4-cycle slot.
REQ-030 rst_n pulsed low mid-cycle during slot 4 -> AN=3Fh, SEG=7Fh immediately, without waiting for a clock edge; FRAME stays 0; after release, scan restarts at A showing 40h (SH=0).
REQ-031 MATRICULA_LZB_EN defined with inputs 000305h -> slots A-C blank (7Fh); D,E,F show 30h,40h,12h; inputs 000000h -> only F shows 40h.
REQ-032 FRAME width check over 10 frames -> each pulse exactly 1 cycle wide, spaced exactly 24 cycles apart.
